// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch/jump and
// multi-cycle mult/div occupancy of EX, plus saturating hazard statistics.
//
// state | meaning
// RUN   | normal issue; load-use, branch/jump and MDU start are evaluated
// BUSY  | mult/div holds EX; front end frozen until the down-counter hits zero
module pipeline_hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_uses_rt,
  input  logic             IDEX_mem_read,
  input  logic [4:0]       IDEX_Rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mdu_start,
  input  logic             mdu_op,
  output logic             pc_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] load_stalls,
  output logic [CNT_W-1:0] mdu_stalls
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {RUN, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] load_stalls_q, mdu_stalls_q;
  logic             load_use;
  logic             ls_inc, ms_inc;

  assign load_use = IDEX_mem_read && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_uses_rt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    pc_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ls_inc      = 1'b0;
    ms_inc      = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mdu_start) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_flush = 1'b1;
            ms_inc      = 1'b1;
            state_d     = BUSY;
            cnt_d       = mdu_op ? CW'(DIV_CYCLES - 2) : CW'(MULT_CYCLES - 2);
          end else if (load_use) begin
            // branch in ID is held back; it re-resolves next cycle with the same instruction
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
            ls_inc     = 1'b1;
          end else if (branch_taken || jump) begin
            IFID_flush = 1'b1;
          end
        end
        BUSY: begin
          mdu_busy = 1'b1;
          if (cnt_q != '0) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_flush = 1'b1;
            ms_inc      = 1'b1;
            cnt_d       = cnt_q - 1'b1;
          end else begin
            mdu_done = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      load_stalls_q <= '0;
      mdu_stalls_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ls_inc && !(&load_stalls_q)) load_stalls_q <= load_stalls_q + 1'b1;
      if (ms_inc && !(&mdu_stalls_q))  mdu_stalls_q  <= mdu_stalls_q + 1'b1;
    end
  end

  assign load_stalls = load_stalls_q;
  assign mdu_stalls  = mdu_stalls_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs of that cycle.
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic IFID_uses_rt, IDEX_mem_read, branch_taken, jump, mdu_start, mdu_op;
  logic pc_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_flush;
  logic mdu_busy, mdu_done;
  logic [CNT_W-1:0] load_stalls, mdu_stalls;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULT_CYCLES(4), .DIV_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
    .IDEX_mem_read(IDEX_mem_read), .IDEX_Rt(IDEX_Rt),
    .branch_taken(branch_taken), .jump(jump),
    .mdu_start(mdu_start), .mdu_op(mdu_op),
    .pc_write(pc_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .load_stalls(load_stalls), .mdu_stalls(mdu_stalls)
  );

  // {pc_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_flush, mdu_busy, mdu_done}
  localparam logic [7:0] O_NORM = 8'b111_000_00;
  localparam logic [7:0] O_RST  = 8'b000_111_00;
  localparam logic [7:0] O_LU   = 8'b001_010_00;
  localparam logic [7:0] O_BR   = 8'b111_100_00;
  localparam logic [7:0] O_MDUS = 8'b000_001_00;
  localparam logic [7:0] O_MDUB = 8'b000_001_10;
  localparam logic [7:0] O_DONE = 8'b111_000_11;

  typedef struct packed {
    logic [7:0]       o;
    logic [CNT_W-1:0] ls;
    logic [CNT_W-1:0] ms;
    logic             chk_cnt;
    logic [7:0]       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] exp_ls = '0, exp_ms = '0;
  logic cnt_known = 1'b0;
  logic [7:0] tag = 8'd0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pc_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_flush,
             mdu_busy, mdu_done};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL ctrl vec%0d: got %b expected %b", e.tag, act, e.o);
      end
      if (e.chk_cnt) begin
        checks += 2;
        if (load_stalls !== e.ls) begin
          errors++;
          $display("FAIL load_stalls vec%0d: got %0d expected %0d", e.tag, load_stalls, e.ls);
        end
        if (mdu_stalls !== e.ms) begin
          errors++;
          $display("FAIL mdu_stalls vec%0d: got %0d expected %0d", e.tag, mdu_stalls, e.ms);
        end
      end
    end
  end

  // One cycle of stimulus plus its expected response; inc_* and clr advance the
  // hand-tracked counter expectations for the following cycles.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] xrt,
                      input logic br, input logic jp, input logic ms, input logic mo,
                      input logic [7:0] o, input bit inc_ls, input bit inc_ms, input bit clr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; IFID_Rs = rs; IFID_Rt = rt; IFID_uses_rt = ur;
    IDEX_mem_read = mr; IDEX_Rt = xrt; branch_taken = br; jump = jp;
    mdu_start = ms; mdu_op = mo;
    e.o = o; e.ls = exp_ls; e.ms = exp_ms; e.chk_cnt = cnt_known; e.tag = tag;
    q.push_back(e);
    tag++;
    if (clr) begin
      exp_ls = '0; exp_ms = '0; cnt_known = 1'b1;
    end else begin
      if (inc_ls && exp_ls != 4'hF) exp_ls++;
      if (inc_ms && exp_ms != 4'hF) exp_ms++;
    end
  endtask

  task automatic idle(input logic [7:0] o);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, o, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; IFID_Rs = 0; IFID_Rt = 0; IFID_uses_rt = 0; IDEX_mem_read = 0;
    IDEX_Rt = 0; branch_taken = 0; jump = 0; mdu_start = 0; mdu_op = 0;

    // reset
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RST, 0, 0, 1);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RST, 0, 0, 1);
    idle(O_NORM);

    // load-use on Rs, then the load has moved on
    step(1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0, O_LU, 1, 0, 0);
    idle(O_NORM);
    // Rt match without uses_rt: no stall; with uses_rt: stall; Rt=0 never stalls
    step(1, 5'd3, 5'd8, 0, 1, 5'd8, 0, 0, 0, 0, O_NORM, 0, 0, 0);
    step(1, 5'd3, 5'd8, 1, 1, 5'd8, 0, 0, 0, 0, O_LU, 1, 0, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, O_NORM, 0, 0, 0);
    idle(O_NORM);

    // multiply with mdu_start held through done, then dropped
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_MDUS, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_MDUB, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_MDUB, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_DONE, 0, 0, 0);
    idle(O_NORM);
    idle(O_NORM);

    // divide with load-use and taken branch present while busy
    step(1, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_MDUS, 0, 1, 0);
    for (int i = 0; i < 6; i++)
      step(1, 5'd9, 5'd0, 0, 1, 5'd9, 1, 0, 0, 0, O_MDUB, 0, 1, 0);
    step(1, 5'd9, 5'd0, 0, 1, 5'd9, 1, 0, 0, 0, O_DONE, 0, 0, 0);
    idle(O_NORM);

    // branch / jump
    step(1, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0, 0, O_BR, 0, 0, 0);
    step(1, 5'd4, 5'd5, 1, 0, 5'd0, 0, 1, 0, 0, O_BR, 0, 0, 0);
    step(1, 5'd4, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, O_LU, 1, 0, 0);
    step(1, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0, 0, O_BR, 0, 0, 0);
    idle(O_NORM);

    // reset in divide cycle 3 aborts without done
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_MDUS, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_MDUB, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RST, 0, 0, 1);
    for (int i = 0; i < 8; i++) idle(O_NORM);

    // saturation of a 4-bit load_stalls counter
    for (int i = 0; i < 20; i++)
      step(1, 5'd12, 5'd0, 0, 1, 5'd12, 0, 0, 0, 0, O_LU, 1, 0, 0);
    idle(O_NORM);
    idle(O_NORM);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    if (exp_ls != 4'hF) begin
      errors++;
      $display("FAIL sat_model: tracked load_stalls %0d, required 15", exp_ls);
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required stimulus completion");
    $fatal(1, "timeout");
  end

endmodule
